// File: rtl/batchnorm_acc_norm.sv
// batchnorm_acc_norm: per-channel batch sum/sum-of-squares accumulator with a 2-stage normalizer.
// Define BN_SATURATE_EN to saturate sum_out/sum_sq_out/mean/variance/y_out instead of wrapping.
module batchnorm_acc_norm #(
  parameter int WIDTH      = 16,
  parameter int FRAC       = 8,
  parameter int BATCH_SIZE = 10,
  parameter int CHANNELS   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic signed [WIDTH-1:0]    x_in,
  input  logic [4:0]                 channel_in,
  input  logic                       valid_in,
  input  logic [CHANNELS*WIDTH-1:0]  gamma,
  input  logic [CHANNELS*WIDTH-1:0]  beta,
  output logic signed [WIDTH-1:0]    y_out,
  output logic                       valid_out,
  output logic                       stat_valid,
  output logic [4:0]                 stat_channel,
  output logic signed [WIDTH-1:0]    sum_out,
  output logic signed [WIDTH-1:0]    sum_sq_out,
  output logic                       done
);

  localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W = $clog2(BATCH_SIZE + 1);
  localparam int SUM_W = WIDTH + 8;
  localparam int SQ_W  = 2*WIDTH + 8;
  localparam int DW    = 2*WIDTH;
  localparam logic signed [63:0]      BS      = 64'(BATCH_SIZE);
  localparam logic signed [WIDTH-1:0] ONE_LSB = WIDTH'(1);
`ifdef BN_SATURATE_EN
  localparam logic signed [63:0] SAT_MAX = (64'sd1 <<< (WIDTH-1)) - 64'sd1;
  localparam logic signed [63:0] SAT_MIN = -(64'sd1 <<< (WIDTH-1));
`endif

  function automatic logic signed [63:0] sx(input logic signed [WIDTH-1:0] v);
    sx = {{(64-WIDTH){v[WIDTH-1]}}, v};
  endfunction

  function automatic logic signed [WIDTH-1:0] fit(input logic signed [63:0] v);
`ifdef BN_SATURATE_EN
    if (v > SAT_MAX)      fit = WIDTH'(SAT_MAX);
    else if (v < SAT_MIN) fit = WIDTH'(SAT_MIN);
    else                  fit = WIDTH'(v);
`else
    fit = WIDTH'(v);
`endif
  endfunction

  function automatic logic signed [WIDTH-1:0] fit_var(input logic signed [63:0] v);
`ifdef BN_SATURATE_EN
    fit_var = (v > SAT_MAX) ? WIDTH'(SAT_MAX) : WIDTH'(v);
`else
    fit_var = WIDTH'(v);
`endif
  endfunction

  logic [CNT_W-1:0]        r_cnt  [CHANNELS];
  logic signed [SUM_W-1:0] r_sum  [CHANNELS];
  logic signed [SQ_W-1:0]  r_sq   [CHANNELS];
  logic signed [WIDTH-1:0] r_mean [CHANNELS];
  logic signed [WIDTH-1:0] r_var  [CHANNELS];
  logic signed [WIDTH-1:0] w_gam  [CHANNELS];
  logic signed [WIDTH-1:0] w_bet  [CHANNELS];

  logic                    r_stat_valid;
  logic [4:0]              r_stat_ch;
  logic signed [WIDTH-1:0] r_sum_out, r_sq_out;
  logic signed [SUM_W-1:0] r_tot_sum;
  logic signed [SQ_W-1:0]  r_tot_sq;
  logic [CHANNELS-1:0]     r_seen;
  logic                    r_done;

  logic [CW-1:0]           w_ach, w_nch, w_sidx;
  logic                    w_in_range, w_accept, w_complete;
  logic [CNT_W-1:0]        w_new_cnt;
  logic signed [SUM_W-1:0] w_new_sum;
  logic signed [SQ_W-1:0]  w_xsq, w_new_sq;
  logic signed [63:0]      w_mean64, w_var64, w_var_c;
  logic [CHANNELS-1:0]     w_seen_nx;

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      w_gam[c] = gamma[c*WIDTH +: WIDTH];
      w_bet[c] = beta[c*WIDTH +: WIDTH];
    end
  end

  assign w_ach      = CW'(channel_in);
  assign w_in_range = (32'(channel_in) < CHANNELS);
  assign w_accept   = valid_in && en && w_in_range;
  assign w_xsq      = SQ_W'((sx(x_in) * sx(x_in)) >>> FRAC);
  assign w_new_sum  = r_sum[w_ach] + SUM_W'(sx(x_in));
  assign w_new_sq   = r_sq[w_ach] + w_xsq;
  assign w_new_cnt  = r_cnt[w_ach] + CNT_W'(1);
  assign w_complete = w_accept && (w_new_cnt == CNT_W'(BATCH_SIZE));

  // accumulation: a completing sample clears its channel and latches the batch totals
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_cnt[c] <= '0;
        r_sum[c] <= '0;
        r_sq[c]  <= '0;
      end
      r_stat_valid <= 1'b0;
      r_stat_ch    <= '0;
      r_sum_out    <= '0;
      r_sq_out     <= '0;
    end else begin
      r_stat_valid <= w_complete;
      if (w_accept) begin
        r_cnt[w_ach] <= w_complete ? '0 : w_new_cnt;
        r_sum[w_ach] <= w_complete ? '0 : w_new_sum;
        r_sq[w_ach]  <= w_complete ? '0 : w_new_sq;
      end
      if (w_complete) begin
        r_stat_ch <= channel_in;
        r_sum_out <= fit({{(64-SUM_W){w_new_sum[SUM_W-1]}}, w_new_sum});
        r_sq_out  <= fit({{(64-SQ_W){w_new_sq[SQ_W-1]}}, w_new_sq});
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_complete) begin
      r_tot_sum <= w_new_sum;
      r_tot_sq  <= w_new_sq;
    end
  end

  assign w_sidx   = r_stat_ch[CW-1:0];
  assign w_mean64 = {{(64-SUM_W){r_tot_sum[SUM_W-1]}}, r_tot_sum} / BS;
  assign w_var64  = ({{(64-SQ_W){r_tot_sq[SQ_W-1]}}, r_tot_sq} / BS) - ((w_mean64 * w_mean64) >>> FRAC);
  assign w_var_c  = (w_var64 < 64'sd0) ? 64'sd0 : w_var64;

  always_comb begin
    w_seen_nx         = r_seen;
    w_seen_nx[w_sidx] = 1'b1;
  end

  // statistics commit during the stat_valid cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_mean[c] <= '0;
        r_var[c]  <= '0;
      end
      r_seen <= '0;
      r_done <= 1'b0;
    end else if (r_stat_valid) begin
      r_mean[w_sidx] <= fit(w_mean64);
      r_var[w_sidx]  <= fit_var(w_var_c);
      r_seen         <= w_seen_nx;
      r_done         <= r_done | (&w_seen_nx);
    end
  end

  logic signed [WIDTH-1:0] w_var_sel, w_v;
  int                      w_lead;
  logic signed [7:0]       w_shift;
  logic signed [DW-1:0]    w_d;

  assign w_nch     = w_in_range ? w_ach : '0;
  assign w_var_sel = r_var[w_nch];
  assign w_v       = (w_var_sel < ONE_LSB) ? ONE_LSB : w_var_sel;
  assign w_d       = DW'(sx(x_in) - sx(r_mean[w_nch]));

  // shift approximates division by sqrt(variance) via the leading-one position
  always_comb begin
    w_lead = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_v[i]) w_lead = i;
    end
  end
  assign w_shift = 8'((w_lead - FRAC) >>> 1);

  logic signed [DW-1:0]    r_d_p0;
  logic signed [7:0]       r_s_p0;
  logic signed [WIDTH-1:0] r_g_p0, r_b_p0;
  logic                    r_vld_p0, r_vld_p1;
  logic signed [WIDTH-1:0] r_y_p1;

  // stage 0: centred sample, shift and per-channel scale captured at input time
  always_ff @(posedge clk) begin
    if (valid_in) begin
      r_d_p0 <= w_d;
      r_s_p0 <= w_shift;
      r_g_p0 <= w_gam[w_nch];
      r_b_p0 <= w_bet[w_nch];
    end
  end

  logic signed [7:0]    w_neg;
  logic signed [DW-1:0] w_n;
  logic signed [63:0]   w_y64;

  assign w_neg = -r_s_p0;
  assign w_n   = r_s_p0[7] ? (r_d_p0 <<< w_neg) : (r_d_p0 >>> r_s_p0);
  assign w_y64 = ((({{(64-DW){w_n[DW-1]}}, w_n}) * sx(r_g_p0)) >>> FRAC) + sx(r_b_p0);

  // stage 1: scale, shift and output register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_vld_p0 <= 1'b0;
      r_vld_p1 <= 1'b0;
      r_y_p1   <= '0;
    end else begin
      r_vld_p0 <= valid_in;
      r_vld_p1 <= r_vld_p0;
      if (r_vld_p0) r_y_p1 <= fit(w_y64);
    end
  end

  assign y_out        = r_y_p1;
  assign valid_out    = r_vld_p1;
  assign stat_valid   = r_stat_valid;
  assign stat_channel = r_stat_ch;
  assign sum_out      = r_sum_out;
  assign sum_sq_out   = r_sq_out;
  assign done         = r_done;

endmodule

// File: tb/tb_batchnorm_acc_norm.sv
// Directed table-driven bench for batchnorm_acc_norm (WIDTH=16, FRAC=8, BATCH_SIZE=10, CHANNELS=16).
module tb_batchnorm_acc_norm;
  localparam int W  = 16;
  localparam int CH = 16;

  logic          clk = 1'b0;
  logic          rst, en, valid_in;
  logic [W-1:0]  x_in;
  logic [4:0]    channel_in;
  logic [CH*W-1:0] gamma, beta;
  logic [W-1:0]  y_out, sum_out, sum_sq_out;
  logic          valid_out, stat_valid, done;
  logic [4:0]    stat_channel;

  always #5 clk = ~clk;

  batchnorm_acc_norm #(.WIDTH(16), .FRAC(8), .BATCH_SIZE(10), .CHANNELS(16)) dut (
    .clk(clk), .rst(rst), .en(en), .x_in(x_in), .channel_in(channel_in),
    .valid_in(valid_in), .gamma(gamma), .beta(beta), .y_out(y_out),
    .valid_out(valid_out), .stat_valid(stat_valid), .stat_channel(stat_channel),
    .sum_out(sum_out), .sum_sq_out(sum_sq_out), .done(done)
  );

  typedef struct {
    logic       vld;
    logic       en;
    logic [4:0] ch;
    logic [15:0] x;
    logic [15:0] ey;
    logic       es;
    logic [15:0] esum;
    logic [15:0] esq;
  } vec_t;

  vec_t tbl[$];
  int n_cmp = 0;
  int n_bad = 0;

`ifdef BN_SATURATE_EN
  localparam logic [15:0] SAT_SUM = 16'h7FFF, SAT_SQ = 16'h7FFF, SAT_Y = 16'h7FFF, CH1_Y = 16'h8000;
`else
  localparam logic [15:0] SAT_SUM = 16'h8000, SAT_SQ = 16'h0000, SAT_Y = 16'h0000, CH1_Y = 16'h1000;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic e, input logic [4:0] c, input logic [15:0] x,
                     input logic [15:0] ey, input logic es,
                     input logic [15:0] esum, input logic [15:0] esq);
    vec_t v;
    v.vld = 1'b1; v.en = e; v.ch = c; v.x = x; v.ey = ey;
    v.es = es; v.esum = esum; v.esq = esq;
    tbl.push_back(v);
  endtask

  // Streams the table back-to-back; stat checked 1 cycle later, y 2 cycles later.
  task automatic run_tbl();
    int n;
    n = tbl.size();
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i >= 1) begin
        chk($sformatf("stat_valid[%0d]", i-1), stat_valid, tbl[i-1].es);
        if (tbl[i-1].es) begin
          chk($sformatf("stat_channel[%0d]", i-1), stat_channel, tbl[i-1].ch);
          chk($sformatf("sum_out[%0d]", i-1), sum_out, tbl[i-1].esum);
          chk($sformatf("sum_sq_out[%0d]", i-1), sum_sq_out, tbl[i-1].esq);
        end
      end
      if (i >= 2) begin
        chk($sformatf("valid_out[%0d]", i-2), valid_out, tbl[i-2].vld);
        if (tbl[i-2].vld) chk($sformatf("y_out[%0d]", i-2), y_out, tbl[i-2].ey);
      end
      if (i < n) begin
        valid_in = tbl[i].vld; en = tbl[i].en; channel_in = tbl[i].ch; x_in = tbl[i].x;
      end else begin
        valid_in = 1'b0;
      end
    end
    tbl.delete();
  endtask

  function automatic logic [15:0] y_of(input int c);
    if (c == 0)      y_of = 16'h0000;
    else if (c == 1) y_of = CH1_Y;
    else if (c == 5) y_of = 16'h1F00;
    else             y_of = 16'h1000;
  endfunction

  initial begin
    gamma = '0;
    beta  = '0;
    for (int c = 0; c < CH; c++) gamma[c*W +: W] = 16'h0100;
    beta[0 +: W]    = 16'h0080;
    gamma[5*W +: W] = 16'h0200;
    beta[5*W +: W]  = 16'hFF00;

    rst = 1'b0; valid_in = 1'b1; en = 1'b1; x_in = 16'h1234; channel_in = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_y_out", y_out, 0);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_stat_valid", stat_valid, 0);
    chk("rst_stat_channel", stat_channel, 0);
    chk("rst_sum_out", sum_out, 0);
    chk("rst_sum_sq_out", sum_sq_out, 0);
    chk("rst_done", done, 0);
    valid_in = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("post_rst_valid_out", valid_out, 0);

    // channel 0 batch, then probes around the statistics update
    for (int i = 0; i < 5; i++) add(1, 0, 16'h0000, 16'h0080, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(1, 0, 16'h0400, 16'h4080, 0, 0, 0);
    add(1, 0,  16'h0400, 16'h4080, 1, 16'h1400, 16'h5000);
    add(0, 0,  16'h0600, 16'h6080, 0, 0, 0);
    add(0, 0,  16'h0600, 16'h0280, 0, 0, 0);
    add(0, 0,  16'h0200, 16'h0080, 0, 0, 0);
    add(0, 0,  16'h0000, 16'hFF80, 0, 0, 0);
    add(1, 20, 16'h0600, 16'h0280, 0, 0, 0);
    add(0, 0,  16'h0A00, 16'h0480, 0, 0, 0);
    run_tbl();

    // channel 1 overflow batch
    for (int i = 0; i < 9; i++) add(1, 1, 16'h4000, SAT_Y, 0, 0, 0);
    add(1, 1, 16'h4000, SAT_Y, 1, SAT_SUM, SAT_SQ);
    run_tbl();

    // one batch per channel; done only after channel 15
    for (int c = 0; c < 15; c++) begin
      for (int i = 0; i < 9; i++) add(1, 5'(c), 16'h0100, y_of(c), 0, 0, 0);
      add(1, 5'(c), 16'h0100, y_of(c), 1, 16'h0A00, 16'h0A00);
    end
    run_tbl();
    chk("done_before_ch15", done, 0);
    for (int i = 0; i < 9; i++) add(1, 15, 16'h0100, 16'h1000, 0, 0, 0);
    add(1, 15, 16'h0100, 16'h1000, 1, 16'h0A00, 16'h0A00);
    run_tbl();
    chk("done_after_ch15", done, 1);
    repeat (5) @(negedge clk);
    chk("done_sticky", done, 1);

    // partial batch discarded by reset
    for (int i = 0; i < 5; i++) add(1, 2, 16'h0100, 16'h0000, 0, 0, 0);
    run_tbl();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_stat_valid", stat_valid, 0);
    chk("midrst_done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 9; i++) add(1, 2, 16'h0100, 16'h1000, 0, 0, 0);
    add(1, 2, 16'h0100, 16'h1000, 1, 16'h0A00, 16'h0A00);
    run_tbl();

    // channels 3 and 4 complete on consecutive cycles
    for (int i = 0; i < 10; i++) begin
      add(1, 3, 16'h0100, 16'h1000, (i == 9), 16'h0A00, 16'h0A00);
      add(1, 4, 16'h0100, 16'h1000, (i == 9), 16'h0A00, 16'h0A00);
    end
    run_tbl();
    chk("done_after_reset", done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
